// File: rtl/lbp_engine.sv
// 3x3 local-binary-pattern engine: reads a gray frame through a 1-cycle-latency read port and
// writes one 8-bit code per interior pixel. Define LBP_BORDER_EN to zero-fill border codes first.
module lbp_engine #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             gray_req,
    output logic [AW-1:0]    gray_addr,
    input  logic [PIX_W-1:0] gray_data,
    output logic             lbp_write,
    output logic [AW-1:0]    lbp_addr,
    output logic [7:0]       lbp_data,
    output logic             busy,
    output logic             finish
);

`ifdef LBP_BORDER_EN
    typedef enum logic [2:0] {StIdle, StBorder, StLoad, StSlide, StCalc, StWrite, StDone} state_e;

    localparam int unsigned BorderN = 2 * IMG_W + 2 * (IMG_H - 2);

    // Border order: top row, bottom row, left column, right column.
    function automatic logic [AW-1:0] border_addr(input int unsigned i);
        int unsigned a;
        if (i < IMG_W) a = i;
        else if (i < 2 * IMG_W) a = (IMG_H - 1) * IMG_W + i - IMG_W;
        else if (i < 2 * IMG_W + IMG_H - 2) a = (i - 2 * IMG_W + 1) * IMG_W;
        else a = (i - 2 * IMG_W - (IMG_H - 2) + 1) * IMG_W + IMG_W - 1;
        return AW'(a);
    endfunction

    int unsigned bcnt_q;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StSlide, StCalc, StWrite, StDone} state_e;
`endif

    localparam logic [AW-1:0] One = AW'(1);

    // Window slot s is column s/3 (left, centre, right), row s%3 (y-1..y+1).
    function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] xc, input logic [AW-1:0] yc,
                                               input logic [3:0] slot);
        int unsigned col, row;
        col = 32'(slot) / 3;
        row = 32'(slot) % 3;
        return AW'((32'(yc) + row - 32'd1) * IMG_W + 32'(xc) + col - 32'd1);
    endfunction

    state_e           state_q;
    logic [AW-1:0]    x_q, y_q;
    logic [3:0]       slot_q;
    logic             cap_en_q;
    logic [3:0]       cap_slot_q;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] ctr;
    logic [7:0]       code;

    // The last read (bottom-right) is still on gray_data when the code is formed.
    always_comb begin
        ctr     = win_q[4];
        code[0] = (win_q[0] >= ctr);
        code[1] = (win_q[3] >= ctr);
        code[2] = (win_q[6] >= ctr);
        code[3] = (win_q[1] >= ctr);
        code[4] = (win_q[7] >= ctr);
        code[5] = (win_q[2] >= ctr);
        code[6] = (win_q[5] >= ctr);
        code[7] = (gray_data >= ctr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            gray_req   <= 1'b0;
            gray_addr  <= '0;
            lbp_write  <= 1'b0;
            lbp_addr   <= '0;
            lbp_data   <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            x_q        <= One;
            y_q        <= One;
            slot_q     <= '0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
`ifdef LBP_BORDER_EN
            bcnt_q     <= '0;
`endif
        end else begin
            cap_en_q   <= gray_req;
            cap_slot_q <= slot_q;
            if (cap_en_q) win_q[cap_slot_q] <= gray_data;

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        busy   <= 1'b1;
                        finish <= 1'b0;
                        x_q    <= One;
                        y_q    <= One;
`ifdef LBP_BORDER_EN
                        state_q   <= StBorder;
                        lbp_write <= 1'b1;
                        lbp_addr  <= border_addr(0);
                        lbp_data  <= '0;
                        bcnt_q    <= 1;
`else
                        state_q   <= StLoad;
                        gray_req  <= 1'b1;
                        gray_addr <= win_addr(One, One, 4'd0);
                        slot_q    <= 4'd0;
`endif
                    end
                end
`ifdef LBP_BORDER_EN
                StBorder: begin
                    if (bcnt_q < BorderN) begin
                        lbp_addr <= border_addr(bcnt_q);
                        bcnt_q   <= bcnt_q + 1;
                    end else begin
                        lbp_write <= 1'b0;
                        state_q   <= StLoad;
                        gray_req  <= 1'b1;
                        gray_addr <= win_addr(x_q, y_q, 4'd0);
                        slot_q    <= 4'd0;
                    end
                end
`endif
                StLoad, StSlide: begin
                    if (slot_q != 4'd8) begin
                        slot_q    <= slot_q + 4'd1;
                        gray_addr <= win_addr(x_q, y_q, slot_q + 4'd1);
                    end else begin
                        gray_req <= 1'b0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    lbp_write <= 1'b1;
                    lbp_addr  <= AW'(32'(y_q) * IMG_W + 32'(x_q));
                    lbp_data  <= code;
                    state_q   <= StWrite;
                end
                StWrite: begin
                    lbp_write <= 1'b0;
                    if (32'(x_q) < IMG_W - 2) begin
                        x_q <= x_q + One;
                        for (int i = 0; i < 6; i++) win_q[i] <= win_q[i + 3];
                        state_q   <= StSlide;
                        gray_req  <= 1'b1;
                        slot_q    <= 4'd6;
                        gray_addr <= win_addr(x_q + One, y_q, 4'd6);
                    end else if (32'(y_q) < IMG_H - 2) begin
                        x_q       <= One;
                        y_q       <= y_q + One;
                        state_q   <= StLoad;
                        gray_req  <= 1'b1;
                        slot_q    <= 4'd0;
                        gray_addr <= win_addr(One, y_q + One, 4'd0);
                    end else begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        finish  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
